// File: rtl/rv32_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32_instr_encoder
// Purpose  : Builds RV32I instruction words from an operation index and its
//            operand fields. This is the inverse of the core decoder. Each
//            word passes through one output register with valid/ready on
//            both sides. Each emitted word is tagged with a running address.
//            Illegal requests are accepted and dropped, raise a one-cycle
//            error pulse, and bump a saturating error counter.
// Ports    : clk, rst_n (async, active low), addr_clr (sync counter reload)
//            in_valid/in_ready, in_op, in_rd, in_rs1, in_rs2, in_imm
//            out_valid/out_ready, out_instr, out_addr
//            err_pulse, err_cnt
// Revision : 1.0  initial release
// ============================================================================
module rv32_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        addr_clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_pulse,
    output logic [7:0]  err_cnt
);

    localparam logic [31:0] c_step = 32'(ADDR_STEP);

    // Instruction format classes. Shift-immediates get their own class
    // because their legal range and bit 30 differ from the other I-types.
    localparam logic [2:0] c_fmt_none = 3'd0;
    localparam logic [2:0] c_fmt_r    = 3'd1;
    localparam logic [2:0] c_fmt_i    = 3'd2;
    localparam logic [2:0] c_fmt_sh   = 3'd3;
    localparam logic [2:0] c_fmt_s    = 3'd4;
    localparam logic [2:0] c_fmt_b    = 3'd5;
    localparam logic [2:0] c_fmt_j    = 3'd6;
    localparam logic [2:0] c_fmt_u    = 3'd7;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    logic [2:0]  w_fmt;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_b30;      // funct7[5]: sub / sra / srai
    logic [31:0] w_instr;
    logic        w_legal;
    logic        w_i_ok;
    logic        w_b_ok;
    logic        w_j_ok;
    logic        w_accept;
    logic        w_load;

    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_addr;
    logic [31:0] r_addr_cnt;
    logic        r_err_pulse;
    logic [7:0]  r_err_cnt;

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_fmt = c_fmt_none;
        w_opc = 7'b0000000;
        w_f3  = 3'b000;
        w_b30 = 1'b0;
        case (in_op)
            6'd0:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b000; end
            6'd1:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b000; w_b30 = 1'b1; end
            6'd2:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b100; end
            6'd3:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b110; end
            6'd4:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b111; end
            6'd5:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b001; end
            6'd6:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b101; end
            6'd7:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b101; w_b30 = 1'b1; end
            6'd8:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b010; end
            6'd9:  begin w_fmt = c_fmt_r;  w_opc = c_opc_op;     w_f3 = 3'b011; end
            6'd10: begin w_fmt = c_fmt_i;  w_opc = c_opc_opimm;  w_f3 = 3'b000; end
            6'd11: begin w_fmt = c_fmt_i;  w_opc = c_opc_opimm;  w_f3 = 3'b100; end
            6'd12: begin w_fmt = c_fmt_i;  w_opc = c_opc_opimm;  w_f3 = 3'b110; end
            6'd13: begin w_fmt = c_fmt_i;  w_opc = c_opc_opimm;  w_f3 = 3'b111; end
            6'd14: begin w_fmt = c_fmt_sh; w_opc = c_opc_opimm;  w_f3 = 3'b001; end
            6'd15: begin w_fmt = c_fmt_sh; w_opc = c_opc_opimm;  w_f3 = 3'b101; end
            6'd16: begin w_fmt = c_fmt_sh; w_opc = c_opc_opimm;  w_f3 = 3'b101; w_b30 = 1'b1; end
            6'd17: begin w_fmt = c_fmt_i;  w_opc = c_opc_opimm;  w_f3 = 3'b010; end
            6'd18: begin w_fmt = c_fmt_i;  w_opc = c_opc_opimm;  w_f3 = 3'b011; end
            6'd19: begin w_fmt = c_fmt_i;  w_opc = c_opc_load;   w_f3 = 3'b000; end
            6'd20: begin w_fmt = c_fmt_i;  w_opc = c_opc_load;   w_f3 = 3'b001; end
            6'd21: begin w_fmt = c_fmt_i;  w_opc = c_opc_load;   w_f3 = 3'b010; end
            6'd22: begin w_fmt = c_fmt_i;  w_opc = c_opc_load;   w_f3 = 3'b100; end
            6'd23: begin w_fmt = c_fmt_i;  w_opc = c_opc_load;   w_f3 = 3'b101; end
            6'd24: begin w_fmt = c_fmt_s;  w_opc = c_opc_store;  w_f3 = 3'b000; end
            6'd25: begin w_fmt = c_fmt_s;  w_opc = c_opc_store;  w_f3 = 3'b001; end
            6'd26: begin w_fmt = c_fmt_s;  w_opc = c_opc_store;  w_f3 = 3'b010; end
            6'd27: begin w_fmt = c_fmt_b;  w_opc = c_opc_branch; w_f3 = 3'b000; end
            6'd28: begin w_fmt = c_fmt_b;  w_opc = c_opc_branch; w_f3 = 3'b001; end
            6'd29: begin w_fmt = c_fmt_b;  w_opc = c_opc_branch; w_f3 = 3'b100; end
            6'd30: begin w_fmt = c_fmt_b;  w_opc = c_opc_branch; w_f3 = 3'b101; end
            6'd31: begin w_fmt = c_fmt_b;  w_opc = c_opc_branch; w_f3 = 3'b110; end
            6'd32: begin w_fmt = c_fmt_b;  w_opc = c_opc_branch; w_f3 = 3'b111; end
            6'd33: begin w_fmt = c_fmt_j;  w_opc = c_opc_jal;    end
            6'd34: begin w_fmt = c_fmt_i;  w_opc = c_opc_jalr;   w_f3 = 3'b000; end
            6'd35: begin w_fmt = c_fmt_u;  w_opc = c_opc_lui;    end
            6'd36: begin w_fmt = c_fmt_u;  w_opc = c_opc_auipc;  end
            default: begin w_fmt = c_fmt_none; end
        endcase
    end

    // Range checks use sign-extension tests: a value fits in N signed bits
    // when every bit from N-1 upward is identical.
    assign w_i_ok = (&in_imm[31:11]) || (~|in_imm[31:11]);
    assign w_b_ok = ((&in_imm[31:12]) || (~|in_imm[31:12])) && !in_imm[0];
    assign w_j_ok = ((&in_imm[31:20]) || (~|in_imm[31:20])) && !in_imm[0];

    // -------------------------------------------------------------- assemble
    always_comb begin
        w_instr = 32'h0000_0000;
        w_legal = 1'b0;
        case (w_fmt)
            c_fmt_r: begin
                w_instr = {1'b0, w_b30, 5'b00000, in_rs2, in_rs1, w_f3, in_rd, w_opc};
                w_legal = 1'b1;
            end
            c_fmt_i: begin
                w_instr = {in_imm[11:0], in_rs1, w_f3, in_rd, w_opc};
                w_legal = w_i_ok;
            end
            c_fmt_sh: begin
                w_instr = {1'b0, w_b30, 5'b00000, in_imm[4:0], in_rs1, w_f3, in_rd, w_opc};
                w_legal = ~|in_imm[31:5];
            end
            c_fmt_s: begin
                w_instr = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], w_opc};
                w_legal = w_i_ok;
            end
            c_fmt_b: begin
                w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                           in_imm[4:1], in_imm[11], w_opc};
                w_legal = w_b_ok;
            end
            c_fmt_j: begin
                w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opc};
                w_legal = w_j_ok;
            end
            c_fmt_u: begin
                w_instr = {in_imm[31:12], in_rd, w_opc};
                w_legal = ~|in_imm[11:0];
            end
            default: begin
                w_instr = 32'h0000_0000;
                w_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------- handshake
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0000_0000;
            r_out_addr  <= BASE_ADDR;
            r_addr_cnt  <= BASE_ADDR;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_err_pulse <= w_accept && !w_legal;

            if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            // A new legal word overwrites the register even while the old
            // one is leaving, so streaming has no bubble.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= addr_clr ? BASE_ADDR : r_addr_cnt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Clear wins over advance; a word loaded alongside the clear
            // took BASE_ADDR, so the counter moves one step past it.
            if (addr_clr) begin
                r_addr_cnt <= w_load ? (BASE_ADDR + c_step) : BASE_ADDR;
            end else if (w_load) begin
                r_addr_cnt <= r_addr_cnt + c_step;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
